// File: rtl/mips_bus_pkg.sv
// Shared definitions for the MIPS data-bus bridge: bus widths, the bridge
// state encoding, the default error read-back word and an address helper.
package mips_bus_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP,
        ST_DONE
    } bridge_state_e;

    // Force a CPU byte address onto the containing 32-bit word.
    function automatic logic [ADDR_W-1:0] wordAlign(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/mips_bus_watchdog.sv
// Bus stall watchdog: counts consecutive cycles a request is held off by
// waitrequest and flags the cycle in which the limit is reached.
// Only instantiated when MIPS_DBRIDGE_TIMEOUT_EN is defined.
module mips_bus_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic count_i,
    input  logic clear_i,
    output logic expired_o
);

    localparam int unsigned      CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;

    // Count stalled request cycles; restart whenever no request is pending.
    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            count_q <= '0;
        end else if (count_i) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign expired_o = count_i && (count_q == LAST);

endmodule

// File: rtl/mips_data_bus_bridge.sv
// Bridges the MIPS CPU data port onto an Avalon-MM master. The CPU is
// stalled via cpu_clk_enable for the whole bus transaction; exactly one bus
// access is issued per CPU access. Optional bus-stall abort is enabled by
// defining MIPS_DBRIDGE_TIMEOUT_EN.
module mips_data_bus_bridge
    import mips_bus_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYCLES = 256,
    parameter logic [DATA_W-1:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_enable_in,
    output logic              cpu_clk_enable,
    input  logic [ADDR_W-1:0] cpu_data_address,
    input  logic              cpu_data_read,
    input  logic              cpu_data_write,
    input  logic [BE_W-1:0]   cpu_byte_enable,
    input  logic [DATA_W-1:0] cpu_data_writedata,
    output logic [DATA_W-1:0] cpu_data_readdata,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [BE_W-1:0]   avm_byteenable,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    output logic              bus_error
);

    bridge_state_e     state_q, state_d;
    logic [ADDR_W-1:0] avmAddress_q;
    logic [BE_W-1:0]   avmByteEnable_q;
    logic [DATA_W-1:0] avmWriteData_q;
    logic              avmRead_q;
    logic              avmWrite_q;
    logic [DATA_W-1:0] readData_q;
    logic              busError_q;

    logic startReq;
    logic acceptReq;
    logic abortReq;
    logic captureRead;
    logic timeoutHit;

`ifdef MIPS_DBRIDGE_TIMEOUT_EN
    mips_bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .count_i  (state_q == ST_REQ && avm_waitrequest),
        .clear_i  (state_q != ST_REQ),
        .expired_o(timeoutHit)
    );
`else
    // No watchdog: a held-off request is waited out indefinitely; the
    // threshold stays referenced so both builds share one parameter set.
    assign timeoutHit = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

    // Next-state and stall decode; the CPU may only run in IDLE and DONE.
    always_comb begin
        state_d        = state_q;
        cpu_clk_enable = clk_enable_in;
        startReq       = 1'b0;
        acceptReq      = 1'b0;
        abortReq       = 1'b0;
        captureRead    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((cpu_data_read || cpu_data_write) && clk_enable_in) begin
                    cpu_clk_enable = 1'b0;
                    startReq       = 1'b1;
                    state_d        = ST_REQ;
                end
            end
            ST_REQ: begin
                cpu_clk_enable = 1'b0;
                if (!avm_waitrequest) begin
                    acceptReq = 1'b1;
                    state_d   = avmWrite_q ? ST_DONE : ST_RESP;
                end else if (timeoutHit) begin
                    abortReq = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_RESP: begin
                cpu_clk_enable = 1'b0;
                captureRead    = 1'b1;
                state_d        = ST_DONE;
            end
            ST_DONE: begin
                if (clk_enable_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (reset) begin
            cpu_clk_enable = clk_enable_in;
        end
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Bus request fields, load data capture and the sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            avmAddress_q    <= '0;
            avmByteEnable_q <= '0;
            avmWriteData_q  <= '0;
            avmRead_q       <= 1'b0;
            avmWrite_q      <= 1'b0;
            readData_q      <= '0;
            busError_q      <= 1'b0;
        end else begin
            if (startReq) begin
                avmAddress_q    <= wordAlign(cpu_data_address);
                avmByteEnable_q <= cpu_byte_enable;
                avmWriteData_q  <= cpu_data_writedata;
                avmWrite_q      <= cpu_data_write;
                avmRead_q       <= ~cpu_data_write;
                if (cpu_data_read && cpu_data_write) begin
                    busError_q <= 1'b1;
                end
            end else if (acceptReq || abortReq) begin
                avmRead_q  <= 1'b0;
                avmWrite_q <= 1'b0;
            end
            if (captureRead) begin
                readData_q <= avm_readdata;
            end else if (abortReq && avmRead_q) begin
                readData_q <= ERR_DATA;
            end
            if (abortReq) begin
                busError_q <= 1'b1;
            end
        end
    end

    assign avm_address       = avmAddress_q;
    assign avm_byteenable    = avmByteEnable_q;
    assign avm_writedata     = avmWriteData_q;
    assign avm_read          = avmRead_q;
    assign avm_write         = avmWrite_q;
    assign cpu_data_readdata = readData_q;
    assign bus_error         = busError_q;

endmodule

// File: tb/tb_mips_data_bus_bridge.sv
// Self-checking bench for mips_data_bus_bridge: a cycle-by-cycle vector
// table plus hand-written sequences for long bus stalls and, when
// MIPS_DBRIDGE_TIMEOUT_EN is defined, the watchdog abort.
module tb_mips_data_bus_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable_in;
    logic        cpu_clk_enable;
    logic [31:0] cpu_data_address;
    logic        cpu_data_read;
    logic        cpu_data_write;
    logic [3:0]  cpu_byte_enable;
    logic [31:0] cpu_data_writedata;
    logic [31:0] cpu_data_readdata;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        bus_error;

    int passed = 0;
    int total  = 0;

    typedef struct {
        string       name;
        logic        rst, ce, rd, wr, waitReq;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata, rdata;
        logic        expCe, expRd, expWr, expErr;
        logic [31:0] expAddr;
        logic [3:0]  expBe;
        logic [31:0] expWd, expData;
    } vector_t;

    vector_t vecs[$];

    mips_data_bus_bridge #(
        .TIMEOUT_CYCLES(4),
        .ERR_DATA      (32'hDEADBEEF)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .clk_enable_in     (clk_enable_in),
        .cpu_clk_enable    (cpu_clk_enable),
        .cpu_data_address  (cpu_data_address),
        .cpu_data_read     (cpu_data_read),
        .cpu_data_write    (cpu_data_write),
        .cpu_byte_enable   (cpu_byte_enable),
        .cpu_data_writedata(cpu_data_writedata),
        .cpu_data_readdata (cpu_data_readdata),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_byteenable    (avm_byteenable),
        .avm_writedata     (avm_writedata),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .bus_error         (bus_error)
    );

    always #5 clk = ~clk;

    task automatic addVec(input string name, input logic rst, ce, rd, wr, waitReq,
                          input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, rdata,
                          input logic expCe, expRd, expWr, expErr,
                          input logic [31:0] expAddr, input logic [3:0] expBe,
                          input logic [31:0] expWd, expData);
        vector_t v;
        v.name = name; v.rst = rst; v.ce = ce; v.rd = rd; v.wr = wr; v.waitReq = waitReq;
        v.addr = addr; v.be = be; v.wdata = wdata; v.rdata = rdata;
        v.expCe = expCe; v.expRd = expRd; v.expWr = expWr; v.expErr = expErr;
        v.expAddr = expAddr; v.expBe = expBe; v.expWd = expWd; v.expData = expData;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vector_t v);
        reset              = v.rst;
        clk_enable_in      = v.ce;
        cpu_data_read      = v.rd;
        cpu_data_write     = v.wr;
        avm_waitrequest    = v.waitReq;
        cpu_data_address   = v.addr;
        cpu_byte_enable    = v.be;
        cpu_data_writedata = v.wdata;
        avm_readdata       = v.rdata;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end else begin
            passed++;
        end
    endtask

    task automatic checkRow(input vector_t v);
        checkOutput({v.name, ".cpu_clk_enable"}, 32'(cpu_clk_enable), 32'(v.expCe));
        checkOutput({v.name, ".avm_read"}, 32'(avm_read), 32'(v.expRd));
        checkOutput({v.name, ".avm_write"}, 32'(avm_write), 32'(v.expWr));
        checkOutput({v.name, ".bus_error"}, 32'(bus_error), 32'(v.expErr));
        checkOutput({v.name, ".avm_address"}, avm_address, v.expAddr);
        checkOutput({v.name, ".avm_byteenable"}, 32'(avm_byteenable), 32'(v.expBe));
        checkOutput({v.name, ".avm_writedata"}, avm_writedata, v.expWd);
        checkOutput({v.name, ".cpu_data_readdata"}, cpu_data_readdata, v.expData);
    endtask

    initial begin
        int readCycles;
        int stall;
        bit finished;

        reset = 1'b1; clk_enable_in = 1'b1; cpu_data_read = 1'b0; cpu_data_write = 1'b0;
        cpu_data_address = '0; cpu_byte_enable = '0; cpu_data_writedata = '0;
        avm_waitrequest = 1'b0; avm_readdata = '0;

        //      name            rst ce rd wr wt addr          be     wdata         rdata          ce rd wr er expAddr       expBe  expWd         expData
        addVec("rst_ce0",       1, 0, 0, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0,         0, 0, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0);
        addVec("rst_ce1",       1, 1, 0, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0,         1, 0, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0);
        addVec("idle",          0, 1, 0, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0,         1, 0, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0);
        addVec("wr_idle",       0, 1, 0, 1, 0, 32'h00001006, 4'hF, 32'h12345678, 32'h0,         0, 0, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0);
        addVec("wr_req",        0, 1, 0, 1, 0, 32'h00001006, 4'hF, 32'h12345678, 32'h0,         0, 0, 1, 0, 32'h00001004, 4'hF, 32'h12345678, 32'h0);
        addVec("wr_done",       0, 1, 0, 1, 0, 32'h00001006, 4'hF, 32'h12345678, 32'h0,         1, 0, 0, 0, 32'h00001004, 4'hF, 32'h12345678, 32'h0);
        addVec("wr_after",      0, 1, 0, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0,         1, 0, 0, 0, 32'h00001004, 4'hF, 32'h12345678, 32'h0);
        addVec("rd_idle",       0, 1, 1, 0, 0, 32'h00002000, 4'hF, 32'h0,        32'h0,         0, 0, 0, 0, 32'h00001004, 4'hF, 32'h12345678, 32'h0);
        addVec("rd_wait1",      0, 1, 1, 0, 1, 32'h00002000, 4'hF, 32'h0,        32'h0,         0, 1, 0, 0, 32'h00002000, 4'hF, 32'h0,        32'h0);
        addVec("rd_wait2",      0, 1, 1, 0, 1, 32'h00002000, 4'hF, 32'h0,        32'h0,         0, 1, 0, 0, 32'h00002000, 4'hF, 32'h0,        32'h0);
        addVec("rd_wait3",      0, 1, 1, 0, 1, 32'h00002000, 4'hF, 32'h0,        32'h0,         0, 1, 0, 0, 32'h00002000, 4'hF, 32'h0,        32'h0);
        addVec("rd_accept",     0, 1, 1, 0, 0, 32'h00002000, 4'hF, 32'h0,        32'h0,         0, 1, 0, 0, 32'h00002000, 4'hF, 32'h0,        32'h0);
        addVec("rd_resp",       0, 1, 1, 0, 0, 32'h00002000, 4'hF, 32'h0,        32'hCAFEF00D,  0, 0, 0, 0, 32'h00002000, 4'hF, 32'h0,        32'h0);
        addVec("rd_done",       0, 1, 1, 0, 0, 32'h00002000, 4'hF, 32'h0,        32'h0,         1, 0, 0, 0, 32'h00002000, 4'hF, 32'h0,        32'hCAFEF00D);
        addVec("rd_after",      0, 1, 0, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0,         1, 0, 0, 0, 32'h00002000, 4'hF, 32'h0,        32'hCAFEF00D);
        addVec("hold_idle",     0, 1, 0, 1, 0, 32'h00003000, 4'h3, 32'hAA55AA55, 32'h0,         0, 0, 0, 0, 32'h00002000, 4'hF, 32'h0,        32'hCAFEF00D);
        addVec("hold_req",      0, 1, 0, 1, 0, 32'h00003000, 4'h3, 32'hAA55AA55, 32'h0,         0, 0, 1, 0, 32'h00003000, 4'h3, 32'hAA55AA55, 32'hCAFEF00D);
        addVec("hold_done1",    0, 0, 0, 1, 0, 32'h00003000, 4'h3, 32'hAA55AA55, 32'h0,         0, 0, 0, 0, 32'h00003000, 4'h3, 32'hAA55AA55, 32'hCAFEF00D);
        addVec("hold_done2",    0, 0, 0, 1, 0, 32'h00003000, 4'h3, 32'hAA55AA55, 32'h0,         0, 0, 0, 0, 32'h00003000, 4'h3, 32'hAA55AA55, 32'hCAFEF00D);
        addVec("hold_exit",     0, 1, 0, 1, 0, 32'h00003000, 4'h3, 32'hAA55AA55, 32'h0,         1, 0, 0, 0, 32'h00003000, 4'h3, 32'hAA55AA55, 32'hCAFEF00D);
        addVec("hold_after",    0, 1, 0, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0,         1, 0, 0, 0, 32'h00003000, 4'h3, 32'hAA55AA55, 32'hCAFEF00D);
        addVec("halted_strobe", 0, 0, 1, 0, 0, 32'h00009000, 4'hF, 32'h0,        32'h0,         0, 0, 0, 0, 32'h00003000, 4'h3, 32'hAA55AA55, 32'hCAFEF00D);
        addVec("halted_none",   0, 1, 0, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0,         1, 0, 0, 0, 32'h00003000, 4'h3, 32'hAA55AA55, 32'hCAFEF00D);
        addVec("rst_idle",      0, 1, 1, 0, 1, 32'h00004000, 4'hF, 32'h0,        32'h0,         0, 0, 0, 0, 32'h00003000, 4'h3, 32'hAA55AA55, 32'hCAFEF00D);
        addVec("rst_req",       0, 1, 1, 0, 1, 32'h00004000, 4'hF, 32'h0,        32'h0,         0, 1, 0, 0, 32'h00004000, 4'hF, 32'h0,        32'hCAFEF00D);
        addVec("rst_assert",    1, 1, 1, 0, 1, 32'h00004000, 4'hF, 32'h0,        32'h0,         1, 1, 0, 0, 32'h00004000, 4'hF, 32'h0,        32'hCAFEF00D);
        addVec("rst_after",     0, 1, 0, 0, 1, 32'h0,        4'h0, 32'h0,        32'h0,         1, 0, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0);
        addVec("both_idle",     0, 1, 1, 1, 0, 32'h0000500B, 4'hC, 32'h0F0F0F0F, 32'h0,         0, 0, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0);
        addVec("both_req",      0, 1, 1, 1, 0, 32'h0000500B, 4'hC, 32'h0F0F0F0F, 32'h0,         0, 0, 1, 1, 32'h00005008, 4'hC, 32'h0F0F0F0F, 32'h0);
        addVec("both_done",     0, 1, 1, 1, 0, 32'h0000500B, 4'hC, 32'h0F0F0F0F, 32'h0,         1, 0, 0, 1, 32'h00005008, 4'hC, 32'h0F0F0F0F, 32'h0);
        addVec("both_after",    0, 1, 0, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0,         1, 0, 0, 1, 32'h00005008, 4'hC, 32'h0F0F0F0F, 32'h0);
        addVec("sticky_idle",   0, 1, 1, 0, 0, 32'h00006000, 4'hF, 32'h0,        32'h0,         0, 0, 0, 1, 32'h00005008, 4'hC, 32'h0F0F0F0F, 32'h0);
        addVec("sticky_req",    0, 1, 1, 0, 0, 32'h00006000, 4'hF, 32'h0,        32'h0,         0, 1, 0, 1, 32'h00006000, 4'hF, 32'h0,        32'h0);
        addVec("sticky_resp",   0, 1, 1, 0, 0, 32'h00006000, 4'hF, 32'h0,        32'h11223344,  0, 0, 0, 1, 32'h00006000, 4'hF, 32'h0,        32'h0);
        addVec("sticky_done",   0, 1, 1, 0, 0, 32'h00006000, 4'hF, 32'h0,        32'h0,         1, 0, 0, 1, 32'h00006000, 4'hF, 32'h0,        32'h11223344);
        addVec("sticky_after",  0, 1, 0, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0,         1, 0, 0, 1, 32'h00006000, 4'hF, 32'h0,        32'h11223344);
        addVec("err_rst",       1, 1, 0, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0,         1, 0, 0, 1, 32'h00006000, 4'hF, 32'h0,        32'h11223344);
        addVec("err_cleared",   0, 1, 0, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0,         1, 0, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0);

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            #2;
            checkRow(vecs[i]);
            @(posedge clk);
            #1;
        end

        // Read held off for two cycles: expect 3 strobe cycles and a 5-cycle stall.
        cpu_data_read = 1'b1; cpu_data_address = 32'h00008000; cpu_byte_enable = 4'hF;
        avm_readdata = 32'h89ABCDEF;
        readCycles = 0; stall = 0; finished = 1'b0;
        for (int k = 0; k < 40 && !finished; k++) begin
            avm_waitrequest = (k >= 1 && k <= 2);
            #2;
            if (avm_read) readCycles++;
            if (!cpu_clk_enable) stall++;
            else finished = 1'b1;
            @(posedge clk);
            #1;
        end
        cpu_data_read = 1'b0; avm_waitrequest = 1'b0; avm_readdata = '0;
        checkOutput("wait2.completed", 32'(finished), 32'd1);
        checkOutput("wait2.read_cycles", 32'(readCycles), 32'd3);
        checkOutput("wait2.stall_cycles", 32'(stall), 32'd5);
        #2;
        checkOutput("wait2.readdata", cpu_data_readdata, 32'h89ABCDEF);
        checkOutput("wait2.bus_error", 32'(bus_error), 32'd0);
        @(posedge clk);
        #1;

`ifdef MIPS_DBRIDGE_TIMEOUT_EN
        // Read never accepted: watchdog drops the strobe after 4 cycles.
        cpu_data_read = 1'b1; cpu_data_address = 32'h00007000; avm_waitrequest = 1'b1;
        readCycles = 0; stall = 0; finished = 1'b0;
        for (int k = 0; k < 40 && !finished; k++) begin
            #2;
            if (avm_read) readCycles++;
            if (!cpu_clk_enable) stall++;
            else finished = 1'b1;
            if (!finished) begin
                @(posedge clk);
                #1;
            end
        end
        checkOutput("timeout.completed", 32'(finished), 32'd1);
        checkOutput("timeout.read_cycles", 32'(readCycles), 32'd4);
        checkOutput("timeout.stall_cycles", 32'(stall), 32'd5);
        checkOutput("timeout.avm_read", 32'(avm_read), 32'd0);
        checkOutput("timeout.readdata", cpu_data_readdata, 32'hDEADBEEF);
        checkOutput("timeout.bus_error", 32'(bus_error), 32'd1);
        @(posedge clk);
        #1;
        cpu_data_read = 1'b0; avm_waitrequest = 1'b0;
        @(posedge clk);
        #1;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mips_data_bus_bridge.md
MIPS_DATA_BUS_BRIDGE -- requirements
Module: mips_data_bus_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 256, max bus wait cycles before abort (used only with MIPS_DBRIDGE_TIMEOUT_EN).
REQ-002 Parameter ERR_DATA, 32'hDEADBEEF, read data returned on aborted read.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 clk_enable_in  input  1  external run/halt enable.
REQ-006 cpu_clk_enable  output  1  drives CPU clk_enable; low = CPU stalled.
REQ-007 cpu_data_address  input  32  CPU data address.
REQ-008 cpu_data_read / cpu_data_write  input  1 each  CPU access strobes.
REQ-009 cpu_byte_enable  input  4  CPU byte lanes.
REQ-010 cpu_data_writedata  input  32  CPU store data.
REQ-011 cpu_data_readdata  output  32  load data to CPU.
REQ-012 avm_address  output  32  word-aligned bus address.
REQ-013 avm_read / avm_write  output  1 each  bus strobes.
REQ-014 avm_byteenable  output  4; avm_writedata  output  32.
REQ-015 avm_waitrequest  input  1  high = request not accepted.
REQ-016 avm_readdata  input  32  valid the cycle after read acceptance.
REQ-017 bus_error  output  1  sticky error flag.

Function
REQ-018 States: IDLE, REQ, RESP, DONE.
REQ-019 IDLE, no strobe: cpu_clk_enable = clk_enable_in; no bus activity.
REQ-020 IDLE, any strobe and clk_enable_in high: cpu_clk_enable=0; latch address ({addr[31:2],2'b00}), byte_enable, writedata, direction; go REQ.
REQ-021 REQ: avm_read or avm_write registered high with latched fields; held stable while avm_waitrequest=1.
REQ-022 REQ, waitrequest=0: strobe deasserted next cycle; write -> DONE, read -> RESP.
REQ-023 RESP: capture avm_readdata into readdata register; go DONE.
REQ-024 DONE: cpu_clk_enable = clk_enable_in; cpu_data_readdata = captured value; leave to IDLE only when clk_enable_in=1, else hold DONE.
REQ-025 cpu_clk_enable=0 in REQ and RESP regardless of clk_enable_in.
REQ-026 Minimum stall: write 2 cycles, read 3 cycles; exactly one bus transaction per CPU access (no reissue in DONE).
REQ-027 Read and write both high: treated as write; bus_error set.
REQ-028 cpu_data_readdata holds last captured value outside DONE.

Reset
REQ-029 On reset: state IDLE; avm_read=avm_write=0; avm_address, avm_byteenable, avm_writedata, cpu_data_readdata = 0; bus_error=0; timeout counter 0.
REQ-030 Reset mid-transaction (REQ/RESP/DONE): abort, IDLE next cycle, strobes low next cycle, no data returned.
REQ-031 cpu_clk_enable equals clk_enable_in while reset is high.

Configuration
REQ-032 Macro MIPS_DBRIDGE_TIMEOUT_EN defined: counter increments each REQ cycle with waitrequest=1; at TIMEOUT_CYCLES drop strobe, set bus_error, load ERR_DATA (reads), go DONE.
REQ-033 Macro undefined: no counter; REQ waits indefinitely; bus_error only from REQ-027.

Structure
REQ-034 Shared package mips_bus_pkg: state enum, ERR_DATA default, bus width constants.
REQ-035 Timeout counter in sub-module mips_bus_watchdog, instantiated only under MIPS_DBRIDGE_TIMEOUT_EN.

Verification
REQ-036 Write addr 32'h0000_1006, be 4'b1111, data 32'h1234_5678, waitrequest=0 -> avm_address 32'h0000_1004, single avm_write pulse, cpu_clk_enable low 2 cycles.
REQ-037 Read 32'h0000_2000, waitrequest high 3 cycles, readdata 32'hCAFE_F00D -> avm_read held 4 cycles, cpu_data_readdata 32'hCAFE_F00D in DONE, stall 6 cycles.
REQ-038 clk_enable_in low in DONE for 2 cycles -> state holds DONE, no new bus strobe, exits when clk_enable_in high.
REQ-039 Reset asserted in REQ with waitrequest=1 -> avm_read 0 and IDLE next cycle, bus_error 0.
REQ-040 With macro, TIMEOUT_CYCLES=4, waitrequest stuck high on read -> strobe drops after 4 cycles, cpu_data_readdata 32'hDEADBEEF, bus_error=1.
REQ-041 Read and write strobes both high -> one avm_write, bus_error=1 and sticky until reset.
